// File: rtl/glitc_clock_delay_scanner.sv
// Clock-phase scanner for the GLITC clock-path IDELAY.
// Sweeps taps 0..31, averages the synchronized N-side sample at each tap,
// locks onto the first low-to-high transition (tap > 0) and applies
// edge + TAP_OFFSET. Manual delay loads pass through while idle.
`timescale 1ns/1ps

module glitc_clock_delay_scanner #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SAMPLE_LOG2   = 6,
    parameter int unsigned TAP_OFFSET    = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       scan_start_i,
    input  logic [4:0] man_delay_i,
    input  logic       man_load_i,
    input  logic       n_q_i,
    output logic [4:0] delay_clk_o,
    output logic       load_clk_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       found_o,
    output logic [4:0] edge_tap_o
);

    localparam int unsigned CNT_W  = (SAMPLE_LOG2 > 8) ? SAMPLE_LOG2 : 8;
    localparam int unsigned ONES_W = SAMPLE_LOG2 + 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'((1 << SAMPLE_LOG2) - 1);
    localparam logic [ONES_W-1:0] HALF        = ONES_W'(1 << (SAMPLE_LOG2 - 1));
    localparam logic [4:0]        OFFSET      = 5'(TAP_OFFSET);

    typedef enum logic [2:0] {
        IDLE, MLOAD, LOAD, SETTLE, SAMPLE, EVAL, APPLY, DONE
    } state_t;

    state_t              state_q, state_d;
    logic                nq_meta, nq_sync;
    logic [4:0]          tap_q;
    logic [4:0]          saved_q;
    logic [4:0]          edge_tap_q;
    logic                found_q;
    logic                prev_cls_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ONES_W-1:0]   ones_q;
    logic                cls;
    logic                is_edge;

    assign cls     = (ones_q >= HALF);
    assign is_edge = (tap_q != 5'd0) && !prev_cls_q && cls;

    // Double-flop synchronizer for the asynchronous N-side clock sample.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            nq_meta <= 1'b0;
            nq_sync <= 1'b0;
        end else begin
            nq_meta <= n_q_i;
            nq_sync <= nq_meta;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode and state-decoded strobes.
    always_comb begin
        state_d    = state_q;
        load_clk_o = 1'b0;
        busy_o     = (state_q != IDLE);
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_start_i)    state_d = LOAD;
                else if (man_load_i) state_d = MLOAD;
            end
            MLOAD: begin
                load_clk_o = 1'b1;
                state_d    = IDLE;
            end
            LOAD: begin
                load_clk_o = 1'b1;
                state_d    = SETTLE;
            end
            SETTLE: if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
            SAMPLE: if (cnt_q == SAMPLE_LAST) state_d = EVAL;
            EVAL: begin
                if (is_edge || tap_q == 5'd31) state_d = APPLY;
                else                            state_d = LOAD;
            end
            APPLY: begin
                load_clk_o = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: delay_clk_o is registered on the edge that enters each load
    // state, so it is already stable for the whole load_clk_o pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            delay_clk_o <= '0;
            tap_q       <= '0;
            saved_q     <= '0;
            edge_tap_q  <= '0;
            found_q     <= 1'b0;
            prev_cls_q  <= 1'b0;
            cnt_q       <= '0;
            ones_q      <= '0;
            found_o     <= 1'b0;
            edge_tap_o  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_start_i) begin
                        saved_q     <= delay_clk_o;
                        tap_q       <= '0;
                        prev_cls_q  <= 1'b0;
                        delay_clk_o <= '0;
                    end else if (man_load_i) begin
                        delay_clk_o <= man_delay_i;
                    end
                end
                LOAD: begin
                    cnt_q  <= '0;
                    ones_q <= '0;
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) cnt_q <= '0;
                    else                      cnt_q <= cnt_q + 1'b1;
                end
                SAMPLE: begin
                    cnt_q  <= cnt_q + 1'b1;
                    ones_q <= ones_q + ONES_W'(nq_sync);
                end
                EVAL: begin
                    if (is_edge) begin
                        found_q     <= 1'b1;
                        edge_tap_q  <= tap_q;
                        delay_clk_o <= tap_q + OFFSET;
                    end else if (tap_q == 5'd31) begin
                        found_q     <= 1'b0;
                        delay_clk_o <= saved_q;
                    end else begin
                        prev_cls_q  <= cls;
                        tap_q       <= tap_q + 5'd1;
                        delay_clk_o <= tap_q + 5'd1;
                    end
                end
                APPLY: begin
                    // Publish the result on entry to DONE so it is valid with done_o.
                    found_o    <= found_q;
                    edge_tap_o <= edge_tap_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_glitc_clock_delay_scanner.sv
// Directed bench for glitc_clock_delay_scanner with a simple N-side clock model
// driven from the applied delay value.
`timescale 1ns/1ps

module tb_glitc_clock_delay_scanner;

    localparam int T_TAP   = 1 + 16 + 64 + 1;
    localparam int MIN_GAP = 16 + 64 + 1;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       scan_start_i = 1'b0;
    logic [4:0] man_delay_i = '0;
    logic       man_load_i = 1'b0;
    logic       n_q_i = 1'b0;
    logic [4:0] delay_clk_o;
    logic       load_clk_o;
    logic       busy_o;
    logic       done_o;
    logic       found_o;
    logic [4:0] edge_tap_o;

    int vectors = 0;
    int miscompares = 0;

    // N-side model: threshold on the applied tap, or a 40%/90% duty dither.
    int thr = 32;
    bit noisy = 1'b0;
    int ph = 0;

    glitc_clock_delay_scanner #(
        .SETTLE_CYCLES(16),
        .SAMPLE_LOG2  (6),
        .TAP_OFFSET   (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .scan_start_i(scan_start_i),
        .man_delay_i (man_delay_i),
        .man_load_i  (man_load_i),
        .n_q_i       (n_q_i),
        .delay_clk_o (delay_clk_o),
        .load_clk_o  (load_clk_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .found_o     (found_o),
        .edge_tap_o  (edge_tap_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive the N-side sample from the current delay setting.
    always @(negedge clk_i) begin
        ph = (ph + 1) % 10;
        if (noisy) n_q_i = (int'(delay_clk_o) >= 12) ? (ph != 0) : ((ph % 5) < 2);
        else       n_q_i = (int'(delay_clk_o) >= thr);
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_man_load(input string tag, input logic [4:0] val);
        man_delay_i = val;
        man_load_i  = 1'b1;
        @(negedge clk_i);
        man_load_i  = 1'b0;
        check_val({tag, "_delay"}, int'(delay_clk_o), int'(val));
        check_val({tag, "_load"},  int'(load_clk_o), 1);
        check_val({tag, "_busy"},  int'(busy_o), 1);
        @(negedge clk_i);
        check_val({tag, "_load_end"}, int'(load_clk_o), 0);
        check_val({tag, "_busy_end"}, int'(busy_o), 0);
    endtask

    // Start a scan and follow it cycle by cycle until done_o or timeout.
    task automatic run_scan(input string tag, input bit collide, input bit inject,
                            input int n_taps, input int exp_delay,
                            input int exp_found, input int exp_edge);
        int busy_cyc, loads, done_cnt, last_c, min_gap, last_delay, tap_err;
        int found_at_done, edge_at_done;
        busy_cyc = 0; loads = 0; done_cnt = 0; last_c = -1; min_gap = 100000;
        last_delay = -1; tap_err = 0; found_at_done = -1; edge_at_done = -1;
        man_delay_i  = 5'd25;
        scan_start_i = 1'b1;
        man_load_i   = collide;
        @(negedge clk_i);
        scan_start_i = 1'b0;
        man_load_i   = 1'b0;
        man_delay_i  = 5'd3;
        for (int c = 0; c < 6000; c++) begin
            man_load_i = inject && (c == 100);
            if (busy_o) busy_cyc++;
            if (load_clk_o) begin
                if (last_c >= 0 && (c - last_c) < min_gap) min_gap = c - last_c;
                if (loads < n_taps && int'(delay_clk_o) != loads) tap_err++;
                last_c = c;
                last_delay = int'(delay_clk_o);
                loads++;
            end
            if (done_o) begin
                done_cnt++;
                found_at_done = int'(found_o);
                edge_at_done  = int'(edge_tap_o);
                break;
            end
            @(negedge clk_i);
        end
        man_load_i = 1'b0;
        check_val({tag, "_done"},   done_cnt, 1);
        check_val({tag, "_busycyc"}, busy_cyc, n_taps * T_TAP + 2);
        check_val({tag, "_loads"},  loads, n_taps + 1);
        check_val({tag, "_taps"},   tap_err, 0);
        check_val({tag, "_gap"},    int'(min_gap >= MIN_GAP), 1);
        check_val({tag, "_delay"},  last_delay, exp_delay);
        check_val({tag, "_found"},  found_at_done, exp_found);
        if (exp_found != 0) check_val({tag, "_edge"}, edge_at_done, exp_edge);
        @(negedge clk_i);
        check_val({tag, "_done_end"}, int'(done_o), 0);
        check_val({tag, "_idle"},     int'(busy_o), 0);
        check_val({tag, "_hold"},     int'(delay_clk_o), exp_delay);
    endtask

    initial begin
        int seen;
        int loads;
        int busy_cnt;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check_val("rst_delay", int'(delay_clk_o), 0);
        check_val("rst_load",  int'(load_clk_o), 0);
        check_val("rst_busy",  int'(busy_o), 0);
        check_val("rst_done",  int'(done_o), 0);
        check_val("rst_found", int'(found_o), 0);
        check_val("rst_edge",  int'(edge_tap_o), 0);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Manual load in IDLE.
        do_man_load("man21", 5'd21);

        // Edge at tap 10, with a colliding man_load and a man_load while busy.
        thr = 10;
        run_scan("edge10", 1'b1, 1'b1, 11, 18, 1, 10);

        // No edge: restore manual delay 5.
        do_man_load("man5", 5'd5);
        thr = 32;
        run_scan("noedge", 1'b0, 1'b0, 32, 5, 0, 0);

        // High from tap 0 onwards: tap 0 is never an edge.
        thr = 0;
        run_scan("allhigh", 1'b0, 1'b0, 32, 5, 0, 0);

        // Edge at tap 30 wraps the offset: (30 + 8) mod 32 = 6.
        thr = 30;
        run_scan("edge30", 1'b0, 1'b0, 31, 6, 1, 30);

        // Reset during SAMPLE of tap 7.
        thr = 10;
        scan_start_i = 1'b1;
        @(negedge clk_i);
        scan_start_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 2000; c++) begin
            if (load_clk_o && delay_clk_o == 5'd7) begin
                seen = 1;
                break;
            end
            @(negedge clk_i);
        end
        check_val("abort_tap7_seen", seen, 1);
        repeat (40) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        check_val("abort_delay", int'(delay_clk_o), 0);
        check_val("abort_load",  int'(load_clk_o), 0);
        check_val("abort_busy",  int'(busy_o), 0);
        check_val("abort_done",  int'(done_o), 0);
        check_val("abort_found", int'(found_o), 0);
        check_val("abort_edge",  int'(edge_tap_o), 0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        loads = 0;
        busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (load_clk_o) loads++;
            if (busy_o) busy_cnt++;
        end
        check_val("abort_no_load", loads, 0);
        check_val("abort_no_busy", busy_cnt, 0);
        check_val("abort_delay_after", int'(delay_clk_o), 0);

        // Noisy sampling after the aborted scan: edge at tap 12, applied 20.
        noisy = 1'b1;
        run_scan("noisy", 1'b0, 1'b0, 13, 20, 1, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
